// File: rtl/io_dcache_pkg.sv
// rtl/io_dcache_pkg.sv - shared types and constants for the io_dcache data cache
package io_dcache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_store.sv
// rtl/dcache_store.sv - valid/tag/data arrays with one write port and an async read port
//
// Ports:
//   clk, n_reset            clock, async active-low reset (clears valid bits only)
//   rd_index, rd_offset     async read address
//   rd_valid, rd_tag,       line valid/tag and addressed word
//   rd_data
//   wr_index, wr_offset     write port address
//   wr_data, wr_tag         write port data word and line tag
//   wr_data_en              store wr_data into the addressed word
//   wr_tag_en               store wr_tag and mark the line valid
//   wr_inv                  mark the line invalid
module dcache_store
    import io_dcache_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [OFFSET_W-1:0]   rd_offset,
    output logic                  rd_valid,
    output logic [13-INDEX_W:0]   rd_tag,
    output logic [15:0]           rd_data,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [OFFSET_W-1:0]   wr_offset,
    input  logic [15:0]           wr_data,
    input  logic [13-INDEX_W:0]   wr_tag,
    input  logic                  wr_data_en,
    input  logic                  wr_tag_en,
    input  logic                  wr_inv
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]   valid_q, valid_d;
    logic [13-INDEX_W:0] tag_q  [LINES];
    logic [15:0]         data_q [LINES][LINE_WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

    always_comb begin
        valid_d = valid_q;
        if (wr_inv) begin
            valid_d[wr_index] = 1'b0;
        end else if (wr_tag_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_tag_en) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (wr_data_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

endmodule

// File: rtl/io_dcache.sv
// rtl/io_dcache.sv - direct-mapped write-through, no-write-allocate data cache
//
// Ports:
//   clk, n_reset            clock, async active-low reset
//   address, data_out      CPU word address and write data
//   IO_WC, IO_RC            CPU write / read commands, held while stalled
//   data_in                 read data to CPU (combinational)
//   d_cache_miss            combinational stall to CPU
//   mem_req, mem_we         memory request (held until mem_ack) and direction
//   mem_addr, mem_wdata     memory word address and write data
//   mem_rdata, mem_ack      memory read data and per-word completion pulse
module io_dcache
    import io_dcache_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        IO_WC,
    input  logic        IO_RC,
    output logic [15:0] data_in,
    output logic        d_cache_miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int TAG_W = 14 - INDEX_W;

    state_e                state_q, state_d;
    logic [OFFSET_W-1:0]   cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [15:0]           mem_addr_q, mem_addr_d;
    logic [15:0]           mem_wdata_q, mem_wdata_d;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [15:0]           rd_data;
    logic                  hit;
    logic                  wr_accept;
    logic                  read_miss;

    logic [INDEX_W-1:0]    st_index;
    logic [OFFSET_W-1:0]   st_offset;
    logic [15:0]           st_data;
    logic [TAG_W-1:0]      st_tag;
    logic                  st_data_en, st_tag_en, st_inv;

    dcache_store #(.INDEX_W(INDEX_W)) u_store (
        .clk        (clk),
        .n_reset    (n_reset),
        .rd_index   (address[INDEX_W+1:2]),
        .rd_offset  (address[1:0]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_index   (st_index),
        .wr_offset  (st_offset),
        .wr_data    (st_data),
        .wr_tag     (st_tag),
        .wr_data_en (st_data_en),
        .wr_tag_en  (st_tag_en),
        .wr_inv     (st_inv)
    );

    assign hit          = rd_valid && (rd_tag == address[15:INDEX_W+2]);
    assign read_miss    = IO_RC && !hit;
    assign d_cache_miss = (IO_RC && (!hit || state_q == ST_FILL)) ||
                          (IO_WC && state_q != ST_IDLE);
    assign wr_accept    = IO_WC && !d_cache_miss;
    // Simultaneous read and write to the same address returns the new data.
    assign data_in      = (IO_RC && IO_WC) ? data_out : rd_data;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        st_index    = address[INDEX_W+1:2];
        st_offset   = address[1:0];
        st_data     = data_out;
        st_tag      = address[15:INDEX_W+2];
        st_data_en  = 1'b0;
        st_tag_en   = 1'b0;
        st_inv      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_accept) begin
                    state_d     = ST_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = address;
                    mem_wdata_d = data_out;
                    st_data_en  = hit;
                end else if (read_miss) begin
                    state_d    = ST_FILL;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {address[15:2], 2'b00};
                    st_inv     = 1'b1;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    if (read_miss) begin
                        state_d    = ST_FILL;
                        cnt_d      = '0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {address[15:2], 2'b00};
                        st_inv     = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end
                end
            end
            ST_FILL: begin
                // The line being filled is taken from mem_addr_q, which was
                // latched at fill entry, so the store port follows it.
                st_index  = mem_addr_q[INDEX_W+1:2];
                st_offset = cnt_q;
                st_data   = mem_rdata;
                st_tag    = mem_addr_q[15:INDEX_W+2];
                if (mem_ack) begin
                    st_data_en = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    mem_addr_d = {mem_addr_q[15:2], cnt_q + 1'b1};
                    if (cnt_q == OFFSET_W'(LINE_WORDS - 1)) begin
                        st_tag_en = 1'b1;
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_io_dcache.sv
// tb/tb_io_dcache.sv - directed self-checking bench for io_dcache
module tb_io_dcache;

    logic        clk;
    logic        n_reset;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        IO_WC;
    logic        IO_RC;
    logic [15:0] data_in;
    logic        d_cache_miss;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    io_dcache #(.INDEX_W(4)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .address      (address),
        .data_out     (data_out),
        .IO_WC        (IO_WC),
        .IO_RC        (IO_RC),
        .data_in      (data_in),
        .d_cache_miss (d_cache_miss),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse(input logic [15:0] rdata);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        #1;
    endtask

    logic [15:0] fill_a [4];
    logic [15:0] fill_b [4];

    initial begin
        fill_a[0] = 16'h1111; fill_a[1] = 16'h2222;
        fill_a[2] = 16'h3333; fill_a[3] = 16'h4444;
        fill_b[0] = 16'hA0A0; fill_b[1] = 16'hA1A1;
        fill_b[2] = 16'hA2A2; fill_b[3] = 16'hA3A3;

        n_reset = 1'b0; address = '0; data_out = '0;
        IO_WC = 1'b0; IO_RC = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        #1;
        check("rst_mem_req",   16'(mem_req), 16'h0);
        check("rst_mem_we",    16'(mem_we), 16'h0);
        check("rst_mem_addr",  mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_miss",      16'(d_cache_miss), 16'h0);
        tick(); tick();
        n_reset = 1'b1;
        tick();

        // cold read miss and line fill
        IO_RC = 1'b1; address = 16'h0040;
        #1;
        check("cold_miss", 16'(d_cache_miss), 16'h1);
        check("cold_idle_req", 16'(mem_req), 16'h0);
        tick();
        check("fill_req", 16'(mem_req), 16'h1);
        check("fill_we", 16'(mem_we), 16'h0);
        check("fill_addr0", mem_addr, 16'h0040);
        for (int i = 0; i < 4; i++) begin
            ack_pulse(fill_a[i]);
            if (i < 3) begin
                check("fill_addr_n", mem_addr, 16'h0040 + 16'(i + 1));
                check("fill_stall", 16'(d_cache_miss), 16'h1);
            end
        end
        check("fill_done_miss", 16'(d_cache_miss), 16'h0);
        check("fill_done_data", data_in, 16'h1111);
        check("fill_done_req", 16'(mem_req), 16'h0);

        // read hit
        address = 16'h0042;
        #1;
        check("hit_miss", 16'(d_cache_miss), 16'h0);
        check("hit_data", data_in, 16'h3333);
        tick();
        check("hit_no_req", 16'(mem_req), 16'h0);

        // write hit with write-through
        IO_RC = 1'b0; IO_WC = 1'b1; address = 16'h0041; data_out = 16'hBEEF;
        #1;
        check("wr_hit_stall", 16'(d_cache_miss), 16'h0);
        tick();
        IO_WC = 1'b0; data_out = 16'h0000;
        #1;
        check("wr_req", 16'(mem_req), 16'h1);
        check("wr_we", 16'(mem_we), 16'h1);
        check("wr_addr", mem_addr, 16'h0041);
        check("wr_wdata", mem_wdata, 16'hBEEF);
        IO_RC = 1'b1;
        #1;
        check("rd_during_wr_miss", 16'(d_cache_miss), 16'h0);
        check("rd_during_wr_data", data_in, 16'hBEEF);
        IO_RC = 1'b0;
        ack_pulse(16'h0000);
        check("wr_done_req", 16'(mem_req), 16'h0);

        // write miss: memory only, no allocate
        IO_WC = 1'b1; address = 16'h0400; data_out = 16'h1234;
        tick();
        IO_WC = 1'b0;
        #1;
        check("wrm_addr", mem_addr, 16'h0400);
        check("wrm_wdata", mem_wdata, 16'h1234);
        check("wrm_we", 16'(mem_we), 16'h1);
        ack_pulse(16'h0000);
        IO_RC = 1'b1;
        #1;
        check("wrm_no_alloc", 16'(d_cache_miss), 16'h1);
        IO_RC = 1'b0;
        tick();

        // second write stalls behind a slow write
        IO_WC = 1'b1; address = 16'h0042; data_out = 16'h7777;
        tick();
        address = 16'h0043; data_out = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("wr2_stall", 16'(d_cache_miss), 16'h1);
            check("wr2_hold_wdata", mem_wdata, 16'h7777);
            tick();
        end
        ack_pulse(16'h0000);
        check("wr2_release", 16'(d_cache_miss), 16'h0);
        check("wr2_idle_req", 16'(mem_req), 16'h0);
        tick();
        IO_WC = 1'b0;
        #1;
        check("wr2_addr", mem_addr, 16'h0043);
        check("wr2_wdata", mem_wdata, 16'h5555);
        ack_pulse(16'h0000);

        // simultaneous read+write forwards data_out
        IO_RC = 1'b1; IO_WC = 1'b1; address = 16'h0043; data_out = 16'h5A5A;
        #1;
        check("fwd_data", data_in, 16'h5A5A);
        check("fwd_stall", 16'(d_cache_miss), 16'h0);
        tick();
        IO_WC = 1'b0; IO_RC = 1'b0;
        ack_pulse(16'h0000);
        IO_RC = 1'b1;
        #1;
        check("fwd_stored", data_in, 16'h5A5A);
        address = 16'h0042;
        #1;
        check("wr2_first_stored", data_in, 16'h7777);

        // reset aborts a fill part-way
        address = 16'h0140;
        tick();
        check("abort_fill_req", 16'(mem_req), 16'h1);
        ack_pulse(16'hDEAD);
        ack_pulse(16'hDEAD);
        n_reset = 1'b0;
        #1;
        check("abort_req", 16'(mem_req), 16'h0);
        check("abort_miss", 16'(d_cache_miss), 16'h1);
        IO_RC = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
        IO_RC = 1'b1; address = 16'h0040;
        #1;
        check("post_rst_miss", 16'(d_cache_miss), 16'h1);
        tick();
        check("refill_addr", mem_addr, 16'h0040);
        for (int i = 0; i < 4; i++) begin
            ack_pulse(fill_b[i]);
        end
        check("refill_miss", 16'(d_cache_miss), 16'h0);
        check("refill_data", data_in, 16'hA0A0);
        address = 16'h0043;
        #1;
        check("refill_data3", data_in, 16'hA3A3);
        IO_RC = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_dcache.md
IO_DCACHE -- requirements
Module: io_dcache

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, line-index width: 2**INDEX_W lines of 4 words, tag width 14-INDEX_W; legal 2..6.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and n_reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 n_reset  input  1  asynchronous active-low reset.
REQ-005 address  input  16  CPU data word address; offset [1:0], index [INDEX_W+1:2], tag [15:INDEX_W+2].
REQ-006 data_out  input  16  CPU write data.
REQ-007 IO_WC  input  1  CPU write command, held while stalled.
REQ-008 IO_RC  input  1  CPU read command, held while stalled.
REQ-009 data_in  output  16  read data to CPU.
REQ-010 d_cache_miss  output  1  combinational stall to CPU.
REQ-011 mem_req  output  1  memory request, held until mem_ack.
REQ-012 mem_we  output  1  1 = memory write, 0 = memory read.
REQ-013 mem_addr  output  16  memory word address.
REQ-014 mem_wdata  output  16  memory write data.
REQ-015 mem_rdata  input  16  memory read data, valid with mem_ack.
REQ-016 mem_ack  input  1  one-cycle completion pulse per word.

Function
REQ-017 SHALL be direct-mapped with one valid bit and one tag per line; data array readable combinationally.
REQ-018 hit SHALL equal valid[index] AND tag[index] equal to address tag.
REQ-019 States SHALL be IDLE, WRITE (write-through outstanding) and FILL (line refill).
REQ-020 d_cache_miss SHALL be (IO_RC AND (NOT hit OR state=FILL)) OR (IO_WC AND state/=IDLE).
REQ-021 A read SHALL complete in any cycle with IO_RC=1 and d_cache_miss=0; data_in SHALL be the addressed cached word, zero-latency.
REQ-022 A write SHALL be accepted only in a cycle with IO_WC=1 and d_cache_miss=0; at that edge: latch address/data_out, go to WRITE, and update the cached word if hit (no allocate on miss).
REQ-023 With IO_RC and IO_WC both asserted and no stall, data_in SHALL equal data_out (forwarding, same address).
REQ-024 WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values, stable until mem_ack; on mem_ack go to FILL if IO_RC misses that cycle, else IDLE.
REQ-025 IDLE with IO_RC=1 and miss, and no write accepted, SHALL enter FILL next edge; a read miss in WRITE SHALL wait for WRITE to finish.
REQ-026 FILL SHALL read words 0,1,2,3 of the line in order: mem_req=1, mem_we=0, mem_addr={tag,index,cnt}; each mem_ack stores mem_rdata into word cnt and increments a 2-bit counter.
REQ-027 On the 4th mem_ack SHALL set tag and valid for the line and return to IDLE; the held read then hits with no further stall.
REQ-028 valid[index] SHALL be cleared on FILL entry so partial lines never hit.
REQ-029 mem_req SHALL be 0 in IDLE; mem_ack outside WRITE/FILL SHALL be ignored.
REQ-030 Read hits in WRITE SHALL complete without stall, including to the line being written.

Reset
REQ-031 n_reset low SHALL asynchronously force state=IDLE, fill counter=0, all valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, latched write registers=0; tag and data arrays need no reset.
REQ-032 Reset mid-WRITE or mid-FILL SHALL abort the transaction with no line left valid; d_cache_miss then follows REQ-020 combinationally with all lines invalid.

Structure
REQ-033 Package io_dcache_pkg SHALL hold the state enum, LINE_WORDS=4 and OFFSET_W=2.
REQ-034 One sub-module, dcache_store, SHALL hold the valid, tag and data arrays with one write port and an async read port.

Verification
REQ-035 After reset, IO_RC at 0x0040 -> d_cache_miss=1; four reads at 0x0040..0x0043 returning 0x1111,0x2222,0x3333,0x4444 -> miss drops after the 4th ack, data_in=0x1111.
REQ-036 Read 0x0042 after that fill -> d_cache_miss=0 same cycle, data_in=0x3333, mem_req stays 0.
REQ-037 Write 0xBEEF to 0x0041 (hit) -> accepted with no stall, one memory write of 0xBEEF to 0x0041, then read 0x0041 returns 0xBEEF; write to 0x0400 (miss) -> memory write only, a later read of 0x0400 misses.
REQ-038 Second IO_WC while WRITE is pending with mem_ack delayed 5 cycles -> d_cache_miss=1 for those cycles, then the write is accepted.
REQ-039 IO_RC and IO_WC together at hit 0x0043 with data_out=0x5A5A -> data_in=0x5A5A, no stall.
REQ-040 n_reset pulsed after 2 of 4 fill acks -> mem_req=0 at once; a later read of 0x0040 misses and refills.
